// File: rtl/instruction_loader_pkg.sv
// Shared constants, FSM state encoding and write-port payload for the instruction loader.
package instruction_loader_pkg;

    localparam int unsigned NBITS     = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CELDAS    = 60;
    localparam int unsigned ADDR_STEP = 4;

    localparam logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    typedef struct packed {
        logic [NBITS-1:0] addr;
        logic [NBITS-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/instruction_loader_byte_word_assembler.sv
// Collects four bytes MSB-first into a word; word_valid_c marks the strobe carrying the last byte.
module instruction_loader_byte_word_assembler
    import instruction_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              strobe,
    input  logic [BYTE_W-1:0] data_in,
    output logic [NBITS-1:0]  word_c,
    output logic              word_valid_c
);

    localparam int unsigned SHIFT_W = NBITS - BYTE_W;

    logic [SHIFT_W-1:0] shift_q;
    logic [1:0]         count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (strobe) begin
            shift_q <= {shift_q[SHIFT_W-BYTE_W-1:0], data_in};
            count_q <= count_q + 2'd1;
        end
    end

    // The fourth byte completes the word in the same cycle it arrives.
    assign word_c       = {shift_q, data_in};
    assign word_valid_c = strobe && (count_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte-streamed program into instruction memory, one big-endian word per write.
module instruction_loader
    import instruction_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_done,
    output logic              o_wr_en,
    output logic [NBITS-1:0]  o_wr_addr,
    output logic [NBITS-1:0]  o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [NBITS-1:0]  o_word_count
);

    state_t           state_q;
    state_t           state_d;
    logic             start_c;
    logic             write_c;
    logic             strobe_c;
    logic [NBITS-1:0] word_c;
    logic             word_valid_c;
    logic [NBITS-1:0] ptr_q;
    logic [NBITS-1:0] count_q;
    wr_req_t          wr_q;
    logic             wr_en_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    // Bytes only count while a load is in progress.
    assign strobe_c = i_rx_done && (state_q == RECV);

    instruction_loader_byte_word_assembler u_assembler (
        .clk          (i_clk),
        .rst_n        (i_reset),
        .clear        (start_c),
        .strobe       (strobe_c),
        .data_in      (i_rx_data),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        write_c = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    state_d = RECV;
                    start_c = 1'b1;
                end
            end
            RECV: begin
                if (word_valid_c) begin
                    if (ptr_q <= NBITS'(CELDAS - 1)) begin
                        write_c = 1'b1;
                        if (word_c == HALT_WORD) begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port, pointer and status flags; the address/data pair holds between writes.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            wr_q    <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            wr_en_q <= write_c;
            busy_q  <= (state_d == RECV);
            done_q  <= (state_d == DONE);
            error_q <= (state_d == ERROR);
            if (start_c) begin
                ptr_q   <= '0;
                count_q <= '0;
                wr_q    <= '0;
            end else if (write_c) begin
                wr_q.addr <= ptr_q;
                wr_q.data <= word_c;
                ptr_q     <= ptr_q + NBITS'(ADDR_STEP);
                count_q   <= count_q + NBITS'(1);
            end
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_q.addr;
    assign o_wr_data    = wr_q.data;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_word_count = count_q;

endmodule
